// File: rtl/apb4_master_bridge.sv
// rtl/apb4_master_bridge.sv - APB4 requester converting a valid/ready command/response pair into SETUP/ACCESS transfers
module apb4_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    input  logic [2:0]              cmd_prot,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    output logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [2:0]              PPROT,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // The abort fires on the TIMEOUT_CYCLES-th low-PREADY ACCESS cycle, when the counter
    // still holds the number of earlier low cycles.
    localparam logic [CNT_WIDTH-1:0] TO_LAST =
        CNT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t               state_q;
    state_t               state_d;
    logic [CNT_WIDTH-1:0] wait_cnt;
    logic                 timeout_hit;

    assign cmd_ready   = (state_q == IDLE);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && !PREADY && (wait_cnt == TO_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (PREADY || timeout_hit) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            wait_cnt    <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            PSTRB       <= '0;
            PPROT       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        PSEL     <= 1'b1;
                        PWRITE   <= cmd_write;
                        PADDR    <= cmd_addr;
                        PWDATA   <= cmd_write ? cmd_wdata : '0;
                        PSTRB    <= cmd_write ? cmd_strb : '0;
                        PPROT    <= cmd_prot;
                        wait_cnt <= '0;
                    end
                end
                SETUP: PENABLE <= 1'b1;
                ACCESS: begin
                    if (PREADY) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= PWRITE ? '0 : PRDATA;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                    end else if (timeout_hit) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: if (rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb4_master_bridge.sv
// tb/tb_apb4_master_bridge.sv - directed scoreboard bench for apb4_master_bridge
module tb_apb4_master_bridge;

    logic        PCLK;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    apb4_master_bridge #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16), .CNT_WIDTH(16)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } rsp_t;

    rsp_t sb[$];

    int vectors;
    int miscompares;

    logic        exp_write;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_strb;
    logic [2:0]  exp_prot;

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_rsp(input logic [31:0] rd, input logic err, input logic to);
        rsp_t r;
        r.rdata = rd;
        r.err   = err;
        r.to    = to;
        sb.push_back(r);
    endtask

    task automatic chk_bus(input string tag);
        chk({tag, "_paddr"},  PADDR,  exp_addr);
        chk({tag, "_pwrite"}, PWRITE, exp_write);
        chk({tag, "_pwdata"}, PWDATA, exp_wdata);
        chk({tag, "_pstrb"},  PSTRB,  exp_strb);
        chk({tag, "_pprot"},  PPROT,  exp_prot);
    endtask

    // Entered at a negedge with the bridge idle; returns at the negedge of SETUP.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] p);
        chk("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_strb  = s;
        cmd_prot  = p;
        exp_write = w;
        exp_addr  = a;
        exp_wdata = w ? d : 32'h0;
        exp_strb  = w ? s : 4'h0;
        exp_prot  = p;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        cmd_addr  = ~a;
        cmd_wdata = ~d;
        chk("setup_psel",    PSEL,    1'b1);
        chk("setup_penable", PENABLE, 1'b0);
        chk("setup_cmd_ready", cmd_ready, 1'b0);
        chk_bus("setup");
    endtask

    // ready_at: ACCESS cycle index where PREADY rises (-1 = never).
    task automatic run_access(input int ready_at, input logic [31:0] rd, input logic err,
                              input int exp_cycles);
        int n;
        n = 0;
        @(negedge PCLK);
        for (int k = 0; k < 40; k++) begin
            if (!(PSEL && PENABLE)) break;
            n++;
            chk_bus("access");
            // Strobe with cmd_valid to show commands are ignored mid-transfer.
            cmd_valid = (k == 0);
            PREADY  = (k == ready_at);
            PRDATA  = rd;
            PSLVERR = (k == ready_at) ? err : 1'b1;
            @(negedge PCLK);
            cmd_valid = 1'b0;
        end
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        chk("access_cycles", n, exp_cycles);
        chk("resp_psel",    PSEL,    1'b0);
        chk("resp_penable", PENABLE, 1'b0);
    endtask

    task automatic get_rsp(input int hold);
        rsp_t e;
        chk("sb_nonempty", sb.size() != 0, 1'b1);
        if (sb.size() != 0) e = sb.pop_front();
        else begin
            e.rdata = 32'h0;
            e.err = 1'b0;
            e.to = 1'b0;
        end
        chk("rsp_valid",   rsp_valid,   1'b1);
        chk("rsp_rdata",   rsp_rdata,   e.rdata);
        chk("rsp_err",     rsp_err,     e.err);
        chk("rsp_timeout", rsp_timeout, e.to);
        for (int i = 0; i < hold; i++) begin
            @(negedge PCLK);
            chk("hold_valid",     rsp_valid, 1'b1);
            chk("hold_rdata",     rsp_rdata, e.rdata);
            chk("hold_err",       rsp_err,   e.err);
            chk("hold_cmd_ready", cmd_ready, 1'b0);
            chk("hold_psel",      PSEL,      1'b0);
        end
        rsp_ready = 1'b1;
        @(negedge PCLK);
        rsp_ready = 1'b0;
        chk("post_hs_valid",     rsp_valid, 1'b0);
        chk("post_hs_cmd_ready", cmd_ready, 1'b1);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        PRESETn = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr = '0;
        cmd_wdata = '0;
        cmd_strb = '0;
        cmd_prot = '0;
        rsp_ready = 1'b0;
        PRDATA = '0;
        PREADY = 1'b0;
        PSLVERR = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("rst_psel",    PSEL,    1'b0);
        chk("rst_penable", PENABLE, 1'b0);
        chk("rst_pwrite",  PWRITE,  1'b0);
        chk("rst_paddr",   PADDR,   32'h0);
        chk("rst_pwdata",  PWDATA,  32'h0);
        chk("rst_pstrb",   PSTRB,   4'h0);
        chk("rst_pprot",   PPROT,   3'h0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err",   rsp_err,   1'b0);
        chk("rst_rsp_to",    rsp_timeout, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        PRESETn = 1'b1;
        @(negedge PCLK);

        // Write, zero wait states: rsp_valid three cycles after accept.
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b010);
        push_rsp(32'h0, 1'b0, 1'b0);
        run_access(0, 32'hCAFEF00D, 1'b0, 1);
        get_rsp(0);

        // Read with three wait states; PSLVERR noise during waits is ignored.
        issue(1'b0, 32'h20, 32'hAAAA5555, 4'hF, 3'b001);
        push_rsp(32'h12345678, 1'b0, 1'b0);
        run_access(3, 32'h12345678, 1'b0, 4);
        get_rsp(0);

        // Slave error on write.
        issue(1'b1, 32'h3FC, 32'h01020304, 4'h3, 3'b000);
        push_rsp(32'h0, 1'b1, 1'b0);
        run_access(0, 32'h0, 1'b1, 1);
        get_rsp(0);

        // Timeout: PREADY never rises.
        issue(1'b0, 32'h40, 32'h0, 4'h0, 3'b100);
        push_rsp(32'h0, 1'b1, 1'b1);
        run_access(-1, 32'h55, 1'b0, 16);
        get_rsp(0);

        // PREADY rises on the 16th ACCESS cycle: completion beats the timeout.
        issue(1'b0, 32'h44, 32'h0, 4'h0, 3'b000);
        push_rsp(32'h0BADF00D, 1'b0, 1'b0);
        run_access(15, 32'h0BADF00D, 1'b0, 16);
        get_rsp(0);

        // Response backpressure, then a back-to-back command right after the handshake.
        issue(1'b1, 32'h80, 32'h11223344, 4'h5, 3'b011);
        push_rsp(32'h0, 1'b0, 1'b0);
        run_access(1, 32'hFFFFFFFF, 1'b0, 2);
        get_rsp(5);
        issue(1'b0, 32'h84, 32'h99999999, 4'hA, 3'b111);
        push_rsp(32'h77, 1'b0, 1'b0);
        run_access(2, 32'h77, 1'b0, 3);
        get_rsp(0);

        // Reset during a wait state discards the transfer.
        issue(1'b0, 32'h90, 32'h0, 4'h0, 3'b000);
        PREADY = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("pre_rst_penable", PENABLE, 1'b1);
        #2;
        PRESETn = 1'b0;
        #1;
        chk("async_rst_psel",    PSEL,      1'b0);
        chk("async_rst_penable", PENABLE,   1'b0);
        chk("async_rst_valid",   rsp_valid, 1'b0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            chk("post_rst_cmd_ready", cmd_ready, 1'b1);
            chk("post_rst_valid",     rsp_valid, 1'b0);
            chk("post_rst_psel",      PSEL,      1'b0);
        end
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/apb4_master_bridge.md
Name: apb4_master_bridge

Overview:
APB4 requester (master) that is the counterpart of our APB4 slave: it converts a simple valid/ready command/response interface into APB4 SETUP/ACCESS transfers. It sits between an internal initiator (CPU shim, test sequencer or DMA) and an APB4 completer. It handles PREADY wait states, PSLVERR, APB4 strobes and protection, and a programmable wait-state timeout. One transfer is in flight at a time.

Parameters:
ADDR_WIDTH, 32, width of PADDR/cmd_addr
DATA_WIDTH, 32, width of PWDATA/PRDATA; must be 8, 16 or 32
TIMEOUT_CYCLES, 16, maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout
CNT_WIDTH, 16, width of the wait-state counter; TIMEOUT_CYCLES < 2**CNT_WIDTH

Ports:
PCLK  in  1  APB clock; all logic on rising edge
PRESETn  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  bridge accepts command
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  transfer address
cmd_wdata  in  DATA_WIDTH  write data
cmd_strb  in  DATA_WIDTH/8  write byte strobes
cmd_prot  in  3  APB4 PPROT value
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_WIDTH  read data (0 for writes/timeouts)
rsp_err  out  1  PSLVERR seen or timeout
rsp_timeout  out  1  transfer aborted by timeout
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_WIDTH  APB address
PWDATA  out  DATA_WIDTH  APB write data
PSTRB  out  DATA_WIDTH/8  APB strobes
PPROT  out  3  APB protection
PRDATA  in  DATA_WIDTH  completer read data
PREADY  in  1  completer ready
PSLVERR  in  1  completer error

Behaviour:
- Reset (PRESETn low, asynchronous): state IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, wait counter all 0. Asserting reset mid-transfer drops PSEL/PENABLE immediately; the in-flight transfer is discarded and no response is produced.
- All APB and rsp outputs are registered; cmd_ready = (state == IDLE) combinationally.
- FSM: IDLE -> SETUP on cmd_valid && cmd_ready (cycle T). Command fields are captured at T.
- SETUP (cycle T+1): PSEL=1, PENABLE=0, PADDR/PWRITE/PPROT/PWDATA/PSTRB driven from the captured command. Unconditionally -> ACCESS.
- ACCESS (T+2 onward): PSEL=1, PENABLE=1. All APB outputs are held stable until completion.
  - PREADY=1: capture PRDATA (reads only; writes return 0) and PSLVERR into rsp_err, with rsp_timeout=0. Next cycle: PSEL=PENABLE=0, rsp_valid=1, state RESP. Minimum command-accept-to-rsp_valid latency is 3 cycles.
  - PREADY=0: wait counter increments. When TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES with PREADY still low, abort: next cycle PSEL=PENABLE=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0, state RESP.
  - PREADY and the timeout in the same cycle: PREADY wins, i.e. a normal completion.
- RESP: rsp_valid stays 1 and rsp fields stay stable until rsp_ready=1. Then rsp_valid=0 and the state returns to IDLE next cycle. A new command is therefore accepted at the earliest one cycle after the handshake. The wait counter clears on entry to SETUP.
- Reads: PSTRB forced to 0 and PWDATA forced to 0 (APB4 rule). Writes: PSTRB = cmd_strb.
- PSLVERR is sampled only in ACCESS with PREADY=1 and ignored otherwise.
- cmd_* inputs are ignored outside IDLE. PRDATA is ignored on writes.

Test Plan:
- Write, zero wait: cmd addr=0x10, wdata=0xDEADBEEF, strb=0xF, prot=3'b010 -> SETUP at T+1, ACCESS at T+2 with PREADY=1; rsp_valid at T+3 with err=0 and rdata=0; PSTRB=0xF; PPROT=2.
- Read, 3 wait states: addr=0x20, slave returns 0x12345678 after 3 PREADY-low cycles -> PADDR/PSEL/PENABLE stable for 4 ACCESS cycles; rsp_rdata=0x12345678; PSTRB=0 and PWDATA=0 throughout.
- Error: write to 0x3FC, PSLVERR=1 with PREADY=1 -> rsp_err=1, rsp_timeout=0.
- Timeout: TIMEOUT_CYCLES=16, PREADY held low -> abort after 16 wait cycles; rsp_err=1, rsp_timeout=1, rdata=0; PSEL drops. Repeat with PREADY rising on the 16th cycle -> normal completion.
- Backpressure/back-to-back: hold rsp_ready=0 for 5 cycles -> rsp fields stable, cmd_ready=0, no PSEL; a second command issued after the handshake starts its SETUP one cycle later.
- Reset mid-ACCESS: PRESETn pulsed low during a wait state -> PSEL/PENABLE go 0 asynchronously, no rsp_valid, cmd_ready=1 after release.
